interfpga_frame_scheduler: RTL

//  Sequences the PC->FPGA byte path. Buffers bytes from uart_receiver, issues them one at a

---
 rtl/interfpga_frame_scheduler_pkg.sv | 31 +++
 rtl/interfpga_frame_scheduler_fifo.sv | 53 +++++
 rtl/interfpga_frame_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/interfpga_frame_scheduler_pkg.sv
// Shared definitions for the PC->FPGA frame scheduler: FSM encodings and default frame size.
package interfpga_frame_scheduler_pkg;

   localparam int unsigned DEFAULT_FRAME_LEN = 16;
   localparam int unsigned STATE_W           = 4;

   localparam logic [STATE_W-1:0] ST_IDLE  = 4'd0;
   localparam logic [STATE_W-1:0] ST_POP   = 4'd1;
   localparam logic [STATE_W-1:0] ST_SEND  = 4'd2;
   localparam logic [STATE_W-1:0] ST_W_HI  = 4'd3;
   localparam logic [STATE_W-1:0] ST_W_LO  = 4'd4;
   localparam logic [STATE_W-1:0] ST_TRL   = 4'd5;
   localparam logic [STATE_W-1:0] ST_TSEND = 4'd6;
   localparam logic [STATE_W-1:0] ST_TW_HI = 4'd7;
   localparam logic [STATE_W-1:0] ST_TW_LO = 4'd8;
   localparam logic [STATE_W-1:0] ST_CLEAR = 4'd9;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = ST_IDLE,
      S_POP   = ST_POP,
      S_SEND  = ST_SEND,
      S_W_HI  = ST_W_HI,
      S_W_LO  = ST_W_LO,
      S_TRL   = ST_TRL,
      S_TSEND = ST_TSEND,
      S_TW_HI = ST_TW_HI,
      S_TW_LO = ST_TW_LO,
      S_CLEAR = ST_CLEAR
   } sched_state_e;

endpackage

// File: rtl/interfpga_frame_scheduler_fifo.sv
// Synchronous byte FIFO with a combinationally readable head; a push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module sched_byte_fifo #(
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned WIDTH   = 8
) (
   input  logic             clk,
   input  logic             db_reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned     DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               wr_en;
   logic               rd_en;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge db_reset) begin
      if (db_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/interfpga_frame_scheduler.sv
// Sequences buffered UART bytes into interfpga_send one at a time, drives the crc
// enable/clear, and closes each frame with the CRC8 trailer byte.
module interfpga_frame_scheduler
   import interfpga_frame_scheduler_pkg::*;
#(
   parameter int unsigned FRAME_LEN    = DEFAULT_FRAME_LEN,
   parameter int unsigned FIFO_AW      = 4,
   parameter int unsigned BUSY_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       db_reset,
   input  logic [7:0] i_8_data,
   input  logic       i_data_valid,
   input  logic       i_flush,
   input  logic       i_send_busy,
   input  logic [7:0] i_8_crc,
   output logic [7:0] o_8_send_data,
   output logic       o_send,
   output logic       o_crc_en,
   output logic [7:0] o_8_crc_data,
   output logic       o_crc_clr,
   output logic [7:0] o_8_frame_count,
   output logic       o_overflow,
   output logic       o_timeout,
   output logic       o_busy
);

   localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);
   localparam logic [7:0] TMO_MAX     = 8'(BUSY_TIMEOUT);

   sched_state_e state;
   logic [7:0]   byte_cnt;
   logic [7:0]   tmo;
   logic         flush_pend;
   logic         fifo_pop;
   logic [7:0]   fifo_dout;
   logic         fifo_full;
   logic         fifo_empty;
   logic         payload_done;

   sched_byte_fifo #(
      .FIFO_AW (FIFO_AW),
      .WIDTH   (8)
   ) u_fifo (
      .clk      (clk),
      .db_reset (db_reset),
      .push     (i_data_valid),
      .pop      (fifo_pop),
      .din      (i_8_data),
      .dout     (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign fifo_pop     = (state == S_POP);
   assign payload_done = (byte_cnt == FRAME_LEN_B) || (fifo_empty && flush_pend);
   assign o_8_crc_data = o_8_send_data;
   // Decoded from registered state and FIFO occupancy
   assign o_busy       = (state != S_IDLE) || !fifo_empty;

   always_ff @(posedge clk or posedge db_reset) begin
      if (db_reset) begin
         state           <= S_IDLE;
         byte_cnt        <= '0;
         tmo             <= '0;
         flush_pend      <= 1'b0;
         o_8_send_data   <= '0;
         o_send          <= 1'b0;
         o_crc_en        <= 1'b0;
         o_crc_clr       <= 1'b0;
         o_8_frame_count <= '0;
         o_overflow      <= 1'b0;
         o_timeout       <= 1'b0;
      end else begin
         o_send    <= 1'b0;
         o_crc_en  <= 1'b0;
         o_crc_clr <= 1'b0;
         if (i_flush && (byte_cnt != 8'd0 || !fifo_empty)) flush_pend <= 1'b1;
         if (i_data_valid && fifo_full && !fifo_pop)       o_overflow <= 1'b1;

         case (state)
            S_IDLE: begin
               if (!fifo_empty)                          state <= S_POP;
               else if (flush_pend && byte_cnt != 8'd0)  state <= S_TRL;
            end
            S_POP: begin
               o_8_send_data <= fifo_dout;
               o_send        <= 1'b1;
               o_crc_en      <= 1'b1;
               state         <= S_SEND;
            end
            S_SEND: begin
               byte_cnt <= byte_cnt + 8'd1;
               tmo      <= '0;
               state    <= S_W_HI;
            end
            S_W_HI: begin
               if (i_send_busy) begin
                  state <= S_W_LO;
               end else if (tmo == TMO_MAX) begin
                  o_timeout <= 1'b1;
                  state     <= payload_done ? S_TRL : S_IDLE;
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end
            S_W_LO: begin
               if (!i_send_busy) state <= payload_done ? S_TRL : S_IDLE;
            end
            // crc has absorbed the last payload byte by now
            S_TRL: begin
               o_8_send_data <= i_8_crc;
               o_send        <= 1'b1;
               state         <= S_TSEND;
            end
            S_TSEND: begin
               tmo   <= '0;
               state <= S_TW_HI;
            end
            S_TW_HI, S_TW_LO: begin
               if (state == S_TW_HI && i_send_busy) begin
                  state <= S_TW_LO;
               end else if ((state == S_TW_LO && !i_send_busy) ||
                            (state == S_TW_HI && tmo == TMO_MAX)) begin
                  if (state == S_TW_HI) o_timeout <= 1'b1;
                  o_crc_clr       <= 1'b1;
                  byte_cnt        <= '0;
                  flush_pend      <= 1'b0;
                  o_8_frame_count <= o_8_frame_count + 8'd1;
                  state           <= S_CLEAR;
               end else if (state == S_TW_HI) begin
                  tmo <= tmo + 8'd1;
               end
            end
            S_CLEAR: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
